watch_time_keeper: RTL
======================

Name: watch_time_keeper

Overview:
- Timekeeping and time-setting front end of the watch datapath.
- Generates the 1 s tick, keeps 24 h binary HOUR/MIN/SEC and handles three push-button keys for setting the time.
- Sits directly upstream of the character-LCD display controller, whose BCD separators consume HOUR/MIN/SEC.
- Also supplies EDIT_FIELD and BLINK so the display can flash the field being edited.

Parameters:
- TICK_DIV, 1000: CLK cycles per second tick; legal range ≥2.
- DEB_CYCLES, 20: consecutive stable synchronized samples needed to accept a key level; legal range ≥1.
- BLINK_DIV, 250: CLK cycles per BLINK toggle while in a set mode.

Ports:
- CLK  in  1  system clock; also the LCD clock.
- RESET  in  1  asynchronous, active-high reset.
- KEY_MODE  in  1  raw, asynchronous, bouncy key; high = pressed.
- KEY_UP  in  1  raw key; increment the edited field.
- KEY_DOWN  in  1  raw key; decrement the edited field.
- HOUR  out  7  0..23, binary.
- MIN  out  7  0..59, binary.
- SEC  out  7  0..59, binary.
- EDIT_FIELD  out  2  0=RUN, 1=hour, 2=minute, 3=second.
- BLINK  out  1  field-flash enable for the display.
- SEC_PULSE  out  1  one-cycle strobe when SEC advances from the tick.

Behaviour:
- Interface (already decided): one clock CLK; reset RESET is asynchronous and active-high. All state clears immediately on RESET assertion, independent of CLK. Reset values: HOUR=MIN=SEC=0, EDIT_FIELD=0 (RUN), BLINK=1, SEC_PULSE=0, prescaler=0, blink counter=0, debouncers idle with accepted level 0.
- Key path, per key:
  - 2-flop synchronizer, then a stability counter.
  - The accepted level changes only after DEB_CYCLES consecutive cycles at the new synchronized value.
  - A 0→1 change of the accepted level produces a 1-cycle press pulse.
  - Release produces no pulse.
  - Any glitch shorter than DEB_CYCLES restarts the count and produces no pulse.
  - For a clean edge, the pulse occurs DEB_CYCLES+2 cycles after the first CLK edge that samples the raw key high.
- Prescaler (RUN only):
  - Counts 0..TICK_DIV-1. Tick when count==TICK_DIV-1 and the counter wraps to 0 on that edge.
  - On tick: SEC+1 and SEC_PULSE=1 for that cycle.
  - SEC 59→0 carries MIN+1; MIN 59→0 carries HOUR+1; HOUR 23→0.
  - The whole carry chain resolves on the same edge, so 23:59:59 → 00:00:00 in one cycle.
- Mode FSM, advanced by the MODE pulse: RUN→SET_H→SET_M→SET_S→RUN.
  - While not in RUN: prescaler held at 0, no tick, SEC_PULSE=0.
  - On SET_S→RUN: prescaler restarts at 0, so the first tick comes TICK_DIV cycles after the transition.
- Editing in SET_x:
  - UP pulse increments the field; DOWN pulse decrements it.
  - Each field wraps independently with no carry: hour 23↔0, min/sec 59↔0.
- Simultaneous events:
  - MODE with UP or DOWN in the same cycle: MODE is taken, UP/DOWN dropped.
  - UP and DOWN in the same cycle: both ignored.
  - UP/DOWN pulses in RUN: ignored.
- BLINK:
  - RUN: constant 1, blink counter held at 0.
  - Set modes: toggles every BLINK_DIV cycles, starting at 1.
  - Counter is reset on every mode change and every accepted UP/DOWN, so the edited value is shown immediately.
- Outputs are registered; no combinational path from inputs to outputs.
- Field values can never leave their legal ranges.

Decomposition:
- Shared package watch_pkg holds:
  - mode encoding RUN/SET_H/SET_M/SET_S (2-bit), matching EDIT_FIELD;
  - constants HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59;
  - time field width 7.
- One sub-module key_debounce (parameter DEB_CYCLES; ports CLK, RESET, KEY_RAW, LEVEL, PRESS), instantiated three times.
- Prescaler, mode FSM and time counters stay in the top.

Test Plan:
- Reset: assert RESET mid-count with no clock edge → all outputs at reset values immediately; EDIT_FIELD=0, BLINK=1.
- Run and rollover (TICK_DIV=4, DEB_CYCLES=2):
  - Set 23:59:59 via keys, press MODE to return to RUN.
  - Expected: first SEC_PULSE exactly 4 cycles later, with HOUR/MIN/SEC=00:00:00 on the same edge.
  - SEC_PULSE period thereafter is 4 cycles.
- Edit wrap:
  - In SET_H from hour 0, one DOWN press → 23; one UP press → 0.
  - In SET_M from 59, UP → 0 and HOUR unchanged.
- Debounce:
  - KEY_UP bouncing (high 1 cycle, low 1, high 1) then steady high with DEB_CYCLES=4 → exactly one increment, pulse 6 cycles after the steady-high start.
  - Holding the key for 100 cycles → no further increments.
- Simultaneous:
  - UP and DOWN debounced on the same cycle in SET_M → MIN unchanged.
  - MODE and UP on the same cycle in SET_H → EDIT_FIELD=2 and HOUR unchanged.
- Reset mid-edit: in SET_S with SEC=37, assert RESET → EDIT_FIELD=0, SEC=0; after release, first tick at TICK_DIV cycles.

Source files
------------

// File: rtl/watch_pkg.sv
// -----------------------------------------------------------------------------
// watch_pkg
// Shared definitions for the watch timekeeping front end.
//   mode_t          : RUN / SET_H / SET_M / SET_S, encoded to match EDIT_FIELD
//   TIME_W          : width of the binary HOUR / MIN / SEC fields
//   HOUR_MAX, ...   : last legal value of each field
//   wrap_inc/dec    : single-field increment / decrement with wrap and no carry
// -----------------------------------------------------------------------------
package watch_pkg;

   localparam int TIME_W = 7;

   localparam logic [TIME_W-1:0] HOUR_MAX = 7'd23;
   localparam logic [TIME_W-1:0] MIN_MAX  = 7'd59;
   localparam logic [TIME_W-1:0] SEC_MAX  = 7'd59;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SET_H = 2'd1,
      SET_M = 2'd2,
      SET_S = 2'd3
   } mode_t;

   // Anything at or above max wraps to zero, so a field can never escape its range.
   function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] v,
                                                  input logic [TIME_W-1:0] max);
      return (v >= max) ? '0 : v + 7'd1;
   endfunction

   function automatic logic [TIME_W-1:0] wrap_dec(input logic [TIME_W-1:0] v,
                                                  input logic [TIME_W-1:0] max);
      return ((v == '0) || (v > max)) ? max : v - 7'd1;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronizes one raw push-button, filters bounce and emits a press strobe.
//   CLK, RESET : clock, asynchronous active-high reset
//   KEY_RAW    : raw asynchronous key, high = pressed
//   LEVEL      : accepted (debounced) key level
//   PRESS      : one-cycle strobe on a 0->1 change of LEVEL
// A new level is accepted after DEB_CYCLES consecutive synchronized samples at
// that value; PRESS follows one cycle later, DEB_CYCLES+2 edges after the first
// edge that samples the raw key high.
// -----------------------------------------------------------------------------
module key_debounce #(
   parameter int DEB_CYCLES = 20
) (
   input  logic CLK,
   input  logic RESET,
   input  logic KEY_RAW,
   output logic LEVEL,
   output logic PRESS
);

   localparam int               CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             sync_p0;
   logic             sync_p1;
   logic             level_r;
   logic             level_d;
   logic [CNT_W-1:0] stable_cnt;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sync_p0    <= 1'b0;
         sync_p1    <= 1'b0;
         level_r    <= 1'b0;
         level_d    <= 1'b0;
         stable_cnt <= '0;
         PRESS      <= 1'b0;
      end else begin
         // synchronizer stage 0 -> stage 1
         sync_p0 <= KEY_RAW;
         sync_p1 <= sync_p0;

         // Any sample matching the current level restarts the count, so a
         // glitch shorter than DEB_CYCLES never reaches LEVEL.
         if (sync_p1 == level_r) begin
            stable_cnt <= '0;
         end else if (stable_cnt == CNT_LAST) begin
            level_r    <= sync_p1;
            stable_cnt <= '0;
         end else begin
            stable_cnt <= stable_cnt + CNT_W'(1);
         end

         // press strobe stage: rising edge of the accepted level only
         level_d <= level_r;
         PRESS   <= level_r & ~level_d;
      end
   end

   assign LEVEL = level_r;

endmodule

// File: rtl/watch_time_keeper.sv
// -----------------------------------------------------------------------------
// watch_time_keeper
// 24 h timekeeper with three-key time setting, feeding the LCD controller.
//   CLK, RESET          : clock, asynchronous active-high reset
//   KEY_MODE/UP/DOWN    : raw bouncy keys, high = pressed
//   HOUR, MIN, SEC      : binary time, 0..23 / 0..59 / 0..59
//   EDIT_FIELD          : 0 = RUN, 1 = hour, 2 = minute, 3 = second
//   BLINK               : flash enable for the edited field (1 in RUN)
//   SEC_PULSE           : one-cycle strobe when SEC advances from the tick
// -----------------------------------------------------------------------------
module watch_time_keeper
   import watch_pkg::*;
#(
   parameter int TICK_DIV   = 1000,
   parameter int DEB_CYCLES = 20,
   parameter int BLINK_DIV  = 250
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              KEY_MODE,
   input  logic              KEY_UP,
   input  logic              KEY_DOWN,
   output logic [TIME_W-1:0] HOUR,
   output logic [TIME_W-1:0] MIN,
   output logic [TIME_W-1:0] SEC,
   output logic [1:0]        EDIT_FIELD,
   output logic              BLINK,
   output logic              SEC_PULSE
);

   localparam int               PRE_W    = $clog2(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam int               BLK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

   logic mode_press, up_press, down_press;
   logic unused_mode_level, unused_up_level, unused_down_level;

   mode_t            mode_q, mode_d;
   logic [PRE_W-1:0] pre_cnt;
   logic [BLK_W-1:0] blk_cnt;
   logic             tick;
   logic             edit_up, edit_dn;

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
      .CLK(CLK), .RESET(RESET), .KEY_RAW(KEY_MODE),
      .LEVEL(unused_mode_level), .PRESS(mode_press)
   );

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
      .CLK(CLK), .RESET(RESET), .KEY_RAW(KEY_UP),
      .LEVEL(unused_up_level), .PRESS(up_press)
   );

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
      .CLK(CLK), .RESET(RESET), .KEY_RAW(KEY_DOWN),
      .LEVEL(unused_down_level), .PRESS(down_press)
   );

   // MODE has priority over edits; UP together with DOWN cancels out.
   always_comb begin
      mode_d  = mode_q;
      tick    = (mode_q == RUN) && (pre_cnt == PRE_LAST);
      edit_up = 1'b0;
      edit_dn = 1'b0;
      if (mode_press) begin
         case (mode_q)
            RUN:     mode_d = SET_H;
            SET_H:   mode_d = SET_M;
            SET_M:   mode_d = SET_S;
            SET_S:   mode_d = RUN;
            default: mode_d = RUN;
         endcase
      end else if (mode_q != RUN) begin
         edit_up = up_press & ~down_press;
         edit_dn = down_press & ~up_press;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) mode_q <= RUN;
      else       mode_q <= mode_d;
   end

   assign EDIT_FIELD = mode_q;

   // Prescaler sits at 0 outside RUN, so returning to RUN gives a full second.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pre_cnt   <= '0;
         SEC_PULSE <= 1'b0;
      end else begin
         SEC_PULSE <= tick;
         if (mode_q != RUN || tick) pre_cnt <= '0;
         else                       pre_cnt <= pre_cnt + PRE_W'(1);
      end
   end

   // Whole carry chain resolves in one edge: 23:59:59 -> 00:00:00.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         HOUR <= '0;
         MIN  <= '0;
         SEC  <= '0;
      end else if (tick) begin
         SEC <= wrap_inc(SEC, SEC_MAX);
         if (SEC >= SEC_MAX) begin
            MIN <= wrap_inc(MIN, MIN_MAX);
            if (MIN >= MIN_MAX) HOUR <= wrap_inc(HOUR, HOUR_MAX);
         end
      end else if (edit_up) begin
         case (mode_q)
            SET_H:   HOUR <= wrap_inc(HOUR, HOUR_MAX);
            SET_M:   MIN  <= wrap_inc(MIN, MIN_MAX);
            SET_S:   SEC  <= wrap_inc(SEC, SEC_MAX);
            default: ;
         endcase
      end else if (edit_dn) begin
         case (mode_q)
            SET_H:   HOUR <= wrap_dec(HOUR, HOUR_MAX);
            SET_M:   MIN  <= wrap_dec(MIN, MIN_MAX);
            SET_S:   SEC  <= wrap_dec(SEC, SEC_MAX);
            default: ;
         endcase
      end
   end

   // Blink restarts high on every mode change or accepted edit so the new
   // value is visible immediately.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         blk_cnt <= '0;
         BLINK   <= 1'b1;
      end else if (mode_q == RUN || mode_press || edit_up || edit_dn) begin
         blk_cnt <= '0;
         BLINK   <= 1'b1;
      end else if (blk_cnt == BLK_LAST) begin
         blk_cnt <= '0;
         BLINK   <= ~BLINK;
      end else begin
         blk_cnt <= blk_cnt + BLK_W'(1);
      end
   end

endmodule
